// File: rtl/player_input_arbiter_pkg.sv
// Shared constants, event record and round-robin selection used by the
// player input arbiter and its event interface.
package player_input_pkg;

  localparam int NUM_PLAYERS = 6;
  localparam int VAL_W       = 3;
  localparam int PID_W       = 3;

  typedef struct packed {
    logic [PID_W-1:0] player;
    logic [VAL_W-1:0] value;
  } evt_t;

  // First requester at or after ptr, wrapping; returns 0 when req is empty.
  function automatic logic [PID_W-1:0] rr_pick(input logic [NUM_PLAYERS-1:0] req,
                                               input logic [PID_W-1:0]       ptr);
    logic [PID_W-1:0] pick;
    logic             found;
    int               idx;
    pick  = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_PLAYERS; i++) begin
      idx = (int'(ptr) + i) % NUM_PLAYERS;
      if (!found && req[idx]) begin
        pick  = PID_W'(idx);
        found = 1'b1;
      end else begin
        pick = pick;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/player_input_arbiter_if.sv
// Valid/ready event stream carrying one player press towards the game core.
interface player_input_arbiter_if;
  import player_input_pkg::*;

  logic             evt_valid;
  logic             evt_ready;
  logic [PID_W-1:0] evt_player;
  logic [VAL_W-1:0] evt_value;

  modport master (output evt_valid, output evt_player, output evt_value, input evt_ready);
  modport slave  (input evt_valid, input evt_player, input evt_value, output evt_ready);

endinterface

// File: rtl/player_input_arbiter_strobe_conditioner.sv
// One player strobe: 2-FF synchroniser, stability counter, debounced level
// and a one-cycle press pulse on the debounced rising edge.
module strobe_conditioner #(
  parameter int CNT_W        = 20,
  parameter int DEBOUNCE_MAX = 999_999
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_i,
  output logic level_o,
  output logic press_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_MAX);

  logic             sync1_q, sync2_q;
  logic             level_q, level_d, level_prev_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Count consecutive disagreeing cycles; flip the level once the count saturates.
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_MAX) begin
        level_d = ~level_q;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      cnt_q        <= '0;
      level_q      <= 1'b0;
      level_prev_q <= 1'b0;
    end else begin
      sync1_q      <= raw_i;
      sync2_q      <= sync1_q;
      cnt_q        <= cnt_d;
      level_q      <= level_d;
      level_prev_q <= level_q;
    end
  end

  assign level_o = level_q;
  assign press_o = level_q & ~level_prev_q;

endmodule

// File: rtl/player_input_arbiter.sv
// Debounces six player strobes, captures each press with its value and
// serialises the presses round-robin onto a single valid/ready stream.
module player_input_arbiter
  import player_input_pkg::*;
#(
  parameter int CNT_W        = 20,
  parameter int DEBOUNCE_MAX = 999_999
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_PLAYERS-1:0]       raw_strobe,
  input  logic [NUM_PLAYERS*VAL_W-1:0] raw_val,
  output logic [NUM_PLAYERS-1:0]       db_level,
  player_input_arbiter_if.master       evt,
  output logic [NUM_PLAYERS-1:0]       pending,
  output logic [NUM_PLAYERS-1:0]       overrun,
  input  logic [NUM_PLAYERS-1:0]       overrun_clr
);

  logic [NUM_PLAYERS*VAL_W-1:0] val_s1_q, val_s2_q;
  logic [VAL_W-1:0]             sval_s [NUM_PLAYERS];
  logic [VAL_W-1:0]             slot_q [NUM_PLAYERS];
  logic [VAL_W-1:0]             slot_d [NUM_PLAYERS];
  logic [NUM_PLAYERS-1:0]       press_s, req_s, drain_s;
  logic [NUM_PLAYERS-1:0]       pending_q, pending_d, overrun_q, overrun_d;
  logic [PID_W-1:0]             ptr_q, ptr_d, grant_s;
  logic                         load_s, valid_q, valid_d;
  evt_t                         evt_q, evt_d;

  for (genvar k = 0; k < NUM_PLAYERS; k++) begin : g_ch
    strobe_conditioner #(
      .CNT_W        (CNT_W),
      .DEBOUNCE_MAX (DEBOUNCE_MAX)
    ) u_cond (
      .clk     (clk),
      .rst     (rst),
      .raw_i   (raw_strobe[k]),
      .level_o (db_level[k]),
      .press_o (press_s[k])
    );
  end

  always_comb begin
    for (int k = 0; k < NUM_PLAYERS; k++) begin
      sval_s[k] = val_s2_q[k*VAL_W +: VAL_W];
    end
  end

  // A fresh press competes directly so an idle output picks it up one cycle later.
  always_comb begin
    req_s   = pending_q | press_s;
    grant_s = rr_pick(req_s, ptr_q);
    load_s  = (~valid_q | evt.evt_ready) & (|req_s);
    drain_s = '0;
    if (load_s) begin
      drain_s[grant_s] = 1'b1;
    end else begin
      drain_s = '0;
    end
  end

  // Output register and pointer advance.
  always_comb begin
    evt_d   = evt_q;
    valid_d = valid_q;
    ptr_d   = ptr_q;
    if (load_s) begin
      valid_d      = 1'b1;
      evt_d.player = grant_s;
      evt_d.value  = pending_q[grant_s] ? slot_q[grant_s] : sval_s[grant_s];
      ptr_d        = (grant_s == PID_W'(NUM_PLAYERS - 1)) ? '0 : grant_s + PID_W'(1);
    end else if (evt.evt_ready) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  // Slot bookkeeping: a press racing a drain of the same slot refills it.
  always_comb begin
    for (int k = 0; k < NUM_PLAYERS; k++) begin
      slot_d[k]    = slot_q[k];
      pending_d[k] = pending_q[k] & ~drain_s[k];
      overrun_d[k] = overrun_q[k] & ~overrun_clr[k];
      if (press_s[k]) begin
        if (pending_q[k] && !drain_s[k]) begin
          overrun_d[k] = 1'b1;
        end else if (pending_q[k] || !drain_s[k]) begin
          slot_d[k]    = sval_s[k];
          pending_d[k] = 1'b1;
        end else begin
          pending_d[k] = 1'b0;
        end
      end else begin
        overrun_d[k] = overrun_d[k];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      val_s1_q  <= '0;
      val_s2_q  <= '0;
      pending_q <= '0;
      overrun_q <= '0;
      ptr_q     <= '0;
      valid_q   <= 1'b0;
      evt_q     <= '0;
      for (int k = 0; k < NUM_PLAYERS; k++) begin
        slot_q[k] <= '0;
      end
    end else begin
      val_s1_q  <= raw_val;
      val_s2_q  <= val_s1_q;
      pending_q <= pending_d;
      overrun_q <= overrun_d;
      ptr_q     <= ptr_d;
      valid_q   <= valid_d;
      evt_q     <= evt_d;
      for (int k = 0; k < NUM_PLAYERS; k++) begin
        slot_q[k] <= slot_d[k];
      end
    end
  end

  assign evt.evt_valid  = valid_q;
  assign evt.evt_player = evt_q.player;
  assign evt.evt_value  = evt_q.value;
  assign pending        = pending_q;
  assign overrun        = overrun_q;

endmodule

// File: doc/player_input_arbiter.md
Name: player_input_arbiter

Overview:
- Conditions the six raw Pmod player strobes and their 3-bit value buses, then serialises presses into a single valid/ready event stream.
- Sits directly upstream of the game core.
- Replaces the six free-standing debouncers at top level.
- Also exports debounced strobe levels for the existing player_clk consumers.

Parameters:
- NUM_PLAYERS, 6, number of player channels (fixed at 6 for this design; stream encoding assumes at most 8)
- VAL_W, 3, width of each player value
- CNT_W, 20, debounce counter width
- DEBOUNCE_MAX, 999_999, consecutive stable cycles needed to accept a level change (10 ms at 100 MHz)

Ports:
- clk  in  1  system clock, 100 MHz
- rst  in  1  asynchronous reset, active-high
- raw_strobe  in  NUM_PLAYERS  raw player strobes, active-high, asynchronous to clk; bit k is player k+1
- raw_val  in  NUM_PLAYERS*VAL_W  raw player values; bits [3k+2:3k] belong to player k+1
- db_level  out  NUM_PLAYERS  debounced strobe levels
- evt_valid  out  1  an event is presented
- evt_ready  in  1  consumer accepts the event
- evt_player  out  3  0-based player index of the presented event
- evt_value  out  VAL_W  value captured at that player's press
- pending  out  NUM_PLAYERS  per-player press captured but not yet sent
- overrun  out  NUM_PLAYERS  sticky flag: a press was dropped
- overrun_clr  in  NUM_PLAYERS  one-cycle pulse clears the matching overrun bits

Behaviour:
- Reset is asynchronous and active-high. While rst is high:
  - all outputs are 0;
  - all synchronisers, counters, pending slots and captured values are 0;
  - the round-robin pointer is 0.
- Synchronisation:
  - each raw_strobe bit and each raw_val bit passes through a 2-FF synchroniser;
  - all downstream logic uses only synchronised signals.
- Debounce, per channel:
  - the counter increments every cycle in which the synced strobe differs from db_level[k];
  - the counter resets to 0 on any cycle in which they are equal;
  - when the counter equals DEBOUNCE_MAX while they still differ, db_level[k] toggles on the next edge and the counter clears;
  - a stable change at the synchroniser output therefore reaches db_level after DEBOUNCE_MAX+1 cycles;
  - a glitch shorter than that produces no change.
- Press detect:
  - a press is a cycle where db_level[k] is 1 and its previous-cycle value is 0;
  - on a press, the synced value for player k is captured into that player's slot and pending[k] is set;
  - falling edges generate nothing.
- Overrun:
  - a press while pending[k]=1, with the slot not being drained in that same cycle, leaves the stored value unchanged and sets overrun[k];
  - if a press and a drain of the same slot coincide, the new press wins: pending[k] stays 1 and takes the new value, with no overrun;
  - overrun_clr[k] clears overrun[k];
  - if a set and a clear of overrun[k] coincide, the set wins.
- Arbiter:
  - round-robin over the pending slots;
  - the search starts at pointer p and wraps from NUM_PLAYERS-1 back to 0;
  - after granting player k, p becomes (k+1) mod NUM_PLAYERS.
- Output register:
  - loads when evt_valid=0, or when evt_valid=1 and evt_ready=1 (handshake), and at least one slot is pending;
  - the loaded slot's pending bit clears in the same cycle;
  - a handshake with no slot pending drops evt_valid to 0;
  - at a sustained evt_ready=1, back-to-back events issue every cycle;
  - minimum latency from press-detect cycle to evt_valid is 1 cycle.
- Hold rule: while evt_valid=1 and evt_ready=0, evt_player and evt_value are stable.
- Event ordering:
  - one event is emitted per accepted press;
  - a single player's events are emitted in press order;
  - no player is starved: at most NUM_PLAYERS-1 other grants occur before a pending player is served.

Decomposition:
- Package player_input_pkg holds:
  - constants NUM_PLAYERS=6, VAL_W=3, PID_W=3;
  - the event record typedef with fields player and value.
- One natural sub-module, strobe_conditioner:
  - per-channel 2-FF synchroniser, debounce counter, db_level output and press pulse;
  - instantiated NUM_PLAYERS times.
- The value synchronisers, slots, arbiter and output register live in the parent.

Test Plan:
All scenarios use DEBOUNCE_MAX=4.
- Reset: assert rst mid-stream with pending=6'b000101 -> all outputs 0 immediately, with no clock edge needed; after release, the first grant starts at player 0.
- Debounce: on player 1, a glitch high for 3 cycles -> no db_level change and no event. A level held high for 10 cycles -> db_level[0] rises exactly 2+5 cycles after the raw edge; one event {player=0, value=raw_val[2:0]=3'd5}.
- Simultaneous presses: players 2, 4 and 6 press in the same cycle with values 1, 2 and 3, and evt_ready=1 -> events (1,1), (3,2), (5,3) on consecutive cycles, then evt_valid=0.
- Backpressure: evt_ready=0 for 20 cycles with an event held -> evt_player and evt_value are constant. A second press by the same player sets overrun[k] and keeps the old value. overrun_clr[k] then clears the flag.
- Press during drain: player 3's slot is handshaken out in the same cycle as a new player 3 press with value 7 -> pending[2] stays 1, a next event (2,7) is emitted, and overrun[2] stays 0.
- Fairness: player 1 presses repeatedly while players 2 and 5 stay pending -> the grant order follows the rotating pointer, and each pending player is served within 6 grants.
